// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, requester IDs
// and the DM MemWrBits/MemRBits size codes carried through unchanged.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  // DM MemWrBits
  localparam logic [1:0] WR_WORD = 2'b00;
  localparam logic [1:0] WR_HALF = 2'b01;
  localparam logic [1:0] WR_BYTE = 2'b10;

  // DM MemRBits
  localparam logic [2:0] RD_LW  = 3'b000;
  localparam logic [2:0] RD_LH  = 3'b001;
  localparam logic [2:0] RD_LHU = 3'b010;
  localparam logic [2:0] RD_LB  = 3'b011;
  localparam logic [2:0] RD_LBU = 3'b100;

  // Wide enough for the largest legal LATENCY (15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester channel (req/ack handshake) and DM port bundle for the arbiter.
// master = side that initiates the transfer, slave = side that answers.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          req;
  logic          we;
  logic [1:0]    wrbits;
  logic [2:0]    rbits;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, we, wrbits, rbits, addr, wdata, input ack, rdata);
  modport slave  (input req, we, wrbits, rbits, addr, wdata, output ack, rdata);
endinterface

interface mem_arbiter_mem_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          rd;
  logic          wr;
  logic [1:0]    wrbits;
  logic [2:0]    rbits;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output rd, wr, wrbits, rbits, addr, wdata, input rdata);
  modport slave  (input rd, wr, wrbits, rbits, addr, wdata, output rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between m0 (CPU) and m1 (loader/debug).
// A grant freezes the winner's request, holds it on the port for LATENCY cycles, then acks once.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      m0,
  mem_arbiter_if.slave      m1,
  mem_arbiter_mem_if.master mem,
  output logic              busy,
  output logic              owner
);

  arb_state_e       r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_last, w_last;
  logic             r_owner, w_owner;
  logic             r_we, w_we;
  logic [1:0]       r_wrbits, w_wrbits;
  logic [2:0]       r_rbits, w_rbits;
  logic [AW-1:0]    r_addr, w_addr;
  logic [DW-1:0]    r_wdata, w_wdata;
  logic [DW-1:0]    r_rdata, w_rdata;
  logic             w_gnt_m0, w_gnt_m1, w_access, w_resp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ARB_IDLE;
      r_cnt    <= '0;
      r_last   <= ARB_M1;
      r_owner  <= ARB_M0;
      r_we     <= 1'b0;
      r_wrbits <= '0;
      r_rbits  <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_last   <= w_last;
      r_owner  <= w_owner;
      r_we     <= w_we;
      r_wrbits <= w_wrbits;
      r_rbits  <= w_rbits;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_rdata  <= w_rdata;
    end
  end

  // On a tie the requester that did not win last time goes next.
  assign w_gnt_m0 = m0.req & (~m1.req | (r_last == ARB_M1));
  assign w_gnt_m1 = m1.req & ~w_gnt_m0;

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_last   = r_last;
    w_owner  = r_owner;
    w_we     = r_we;
    w_wrbits = r_wrbits;
    w_rbits  = r_rbits;
    w_addr   = r_addr;
    w_wdata  = r_wdata;
    w_rdata  = r_rdata;
    case (r_state)
      ARB_IDLE: begin
        if (w_gnt_m0 | w_gnt_m1) begin
          w_owner = w_gnt_m1 ? ARB_M1 : ARB_M0;
          w_last  = w_owner;
          if (w_gnt_m1) begin
            w_we = m1.we; w_wrbits = m1.wrbits; w_rbits = m1.rbits;
            w_addr = m1.addr; w_wdata = m1.wdata;
          end else begin
            w_we = m0.we; w_wrbits = m0.wrbits; w_rbits = m0.rbits;
            w_addr = m0.addr; w_wdata = m0.wdata;
          end
          w_cnt   = CNT_W'(LATENCY - 1);
          w_state = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (r_cnt == '0) begin
          if (!r_we) w_rdata = mem.rdata;
          w_state = ARB_RESP;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      ARB_RESP: w_state = ARB_IDLE;
      default:  w_state = ARB_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign w_access   = (r_state == ARB_ACCESS);
  assign w_resp     = (r_state == ARB_RESP);
  assign mem.rd     = w_access & ~r_we;
  assign mem.wr     = w_access & r_we;
  assign mem.wrbits = r_wrbits;
  assign mem.rbits  = r_rbits;
  assign mem.addr   = r_addr;
  assign mem.wdata  = r_wdata;

  assign m0.ack   = w_resp & (r_owner == ARB_M0);
  assign m1.ack   = w_resp & (r_owner == ARB_M1);
  assign m0.rdata = m0.ack ? r_rdata : '0;
  assign m1.rdata = m1.ack ? r_rdata : '0;

  assign busy  = (r_state != ARB_IDLE);
  assign owner = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: two instances (LATENCY 1 and 3) share one clock;
// stimulus pushes expected transactions, a single negedge monitor pops them on ack.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct packed {
    logic        who;
    logic        we;
    logic [1:0]  wb;
    logic [2:0]  rb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, rst_b;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if     #(.AW(32), .DW(32)) a_m0 (), a_m1 (), b_m0 (), b_m1 ();
  mem_arbiter_mem_if #(.AW(32), .DW(32)) a_mem (), b_mem ();
  logic a_busy, a_owner, b_busy, b_owner;

  mem_arbiter #(.LATENCY(1), .AW(32), .DW(32)) u_a (
    .clk(clk), .rst(rst_a), .m0(a_m0), .m1(a_m1), .mem(a_mem), .busy(a_busy), .owner(a_owner));
  mem_arbiter #(.LATENCY(3), .AW(32), .DW(32)) u_b (
    .clk(clk), .rst(rst_b), .m0(b_m0), .m1(b_m1), .mem(b_mem), .busy(b_busy), .owner(b_owner));

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction
  assign a_mem.rdata = mem_fn(a_mem.addr);
  assign b_mem.rdata = mem_fn(b_mem.addr);

  exp_t q[2][$];
  int   run[2], last_s[2], age[2];
  int   n_chk = 0, n_fail = 0;
  bit   fin_req = 0, fin_done = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d actual=%h expected=%h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic mon(input int d, input int lat);
    logic rstn, rd, wr, a0, a1, bsy, own;
    logic [1:0] wb;
    logic [2:0] rb;
    logic [31:0] ad, wd, d0, d1;
    exp_t e;
    if (d == 0) begin
      rstn = rst_a; rd = a_mem.rd; wr = a_mem.wr; wb = a_mem.wrbits; rb = a_mem.rbits;
      ad = a_mem.addr; wd = a_mem.wdata; a0 = a_m0.ack; a1 = a_m1.ack;
      d0 = a_m0.rdata; d1 = a_m1.rdata; bsy = a_busy; own = a_owner;
    end else begin
      rstn = rst_b; rd = b_mem.rd; wr = b_mem.wr; wb = b_mem.wrbits; rb = b_mem.rbits;
      ad = b_mem.addr; wd = b_mem.wdata; a0 = b_m0.ack; a1 = b_m1.ack;
      d0 = b_m0.rdata; d1 = b_m1.rdata; bsy = b_busy; own = b_owner;
    end
    if (!rstn) begin
      chk("rst_rd", d, rd, 0); chk("rst_wr", d, wr, 0); chk("rst_busy", d, bsy, 0);
      chk("rst_acks", d, {a1, a0}, 0); chk("rst_owner", d, own, 0); chk("rst_addr", d, ad, 0);
      q[d].delete(); run[d] = 0; age[d] = 0;
      return;
    end
    if (!a0) chk("m0_rdata_zero", d, d0, 0);
    if (!a1) chk("m1_rdata_zero", d, d1, 0);
    chk("ack_excl", d, a0 & a1, 0);
    chk("busy", d, bsy, rd | wr | a0 | a1);
    if (rd | wr) begin
      if (q[d].size() == 0) chk("strobe_unexpected", d, {rd, wr}, 0);
      else begin
        e = q[d][0];
        chk("mem_rd", d, rd, !e.we); chk("mem_wr", d, wr, e.we);
        chk("mem_addr", d, ad, e.addr); chk("mem_wrbits", d, wb, e.wb); chk("mem_rbits", d, rb, e.rb);
        if (e.we) chk("mem_wdata", d, wd, e.wdata);
        run[d]++; last_s[d] = cyc;
      end
    end
    if (a0 | a1) begin
      if (q[d].size() == 0) chk("ack_unexpected", d, {a1, a0}, 0);
      else begin
        e = q[d].pop_front();
        chk("ack_who", d, a1, e.who); chk("owner", d, own, e.who);
        if (!e.we) chk("rdata", d, e.who ? d1 : d0, e.rdata);
        chk("strobe_len", d, run[d], lat); chk("strobe_end", d, last_s[d], cyc - 1);
        if (e.ack_cyc != 0) chk("ack_cycle", d, cyc, e.ack_cyc);
        run[d] = 0; age[d] = 0;
      end
    end
    if (q[d].size() != 0) begin
      age[d]++;
      if (age[d] > 60) begin
        chk("ack_timeout", d, age[d], 0);
        q[d].delete(); age[d] = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0, 1);
      mon(1, 3);
      if (fin_req && !fin_done) begin
        chk("q_empty", 0, q[0].size(), 0);
        chk("q_empty", 1, q[1].size(), 0);
        fin_done = 1;
      end
    end
  end

  task automatic drive(input int d, input bit who, input bit req, input bit we, input logic [1:0] wb,
                       input logic [2:0] rb, input logic [31:0] addr, input logic [31:0] wd);
    case ({d[0], who})
      2'b00: {a_m0.req, a_m0.we, a_m0.wrbits, a_m0.rbits, a_m0.addr, a_m0.wdata} = {req, we, wb, rb, addr, wd};
      2'b01: {a_m1.req, a_m1.we, a_m1.wrbits, a_m1.rbits, a_m1.addr, a_m1.wdata} = {req, we, wb, rb, addr, wd};
      2'b10: {b_m0.req, b_m0.we, b_m0.wrbits, b_m0.rbits, b_m0.addr, b_m0.wdata} = {req, we, wb, rb, addr, wd};
      default: {b_m1.req, b_m1.we, b_m1.wrbits, b_m1.rbits, b_m1.addr, b_m1.wdata} = {req, we, wb, rb, addr, wd};
    endcase
  endtask

  task automatic push(input int d, input bit who, input bit we, input logic [1:0] wb, input logic [2:0] rb,
                      input logic [31:0] addr, input logic [31:0] wd, input int ack_cyc);
    exp_t e;
    e.who = who; e.we = we; e.wb = wb; e.rb = rb; e.addr = addr; e.wdata = wd;
    e.rdata = mem_fn(addr); e.ack_cyc = ack_cyc;
    q[d].push_back(e);
  endtask

  task automatic wait_acks(input int d, input int n);
    int k = 0;
    for (int i = 0; i < 200 && k < n; i++) begin
      @(negedge clk);
      if (d == 0) k += int'(a_m0.ack) + int'(a_m1.ack);
      else        k += int'(b_m0.ack) + int'(b_m1.ack);
    end
  endtask

  task automatic single(input int d, input bit who, input bit we, input logic [1:0] wb, input logic [2:0] rb,
                        input logic [31:0] addr, input logic [31:0] wd, input int lat);
    @(posedge clk); #1;
    drive(d, who, 1'b1, we, wb, rb, addr, wd);
    push(d, who, we, wb, rb, addr, wd, cyc + lat + 1);
    wait_acks(d, 1);
    drive(d, who, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
  endtask

  // Both requesters held for four transactions; grants must alternate from the current last_grant.
  task automatic fairness(input int d, input int lat);
    int c;
    @(posedge clk); #1;
    c = cyc;
    drive(d, ARB_M0, 1'b1, 1'b0, WR_WORD, RD_LH, 32'h30, 32'h0);
    drive(d, ARB_M1, 1'b1, 1'b1, WR_HALF, RD_LW, 32'h40, 32'hCAFE0001);
    for (int k = 0; k < 4; k++)
      if (k % 2 == 0) push(d, ARB_M0, 1'b0, WR_WORD, RD_LH, 32'h30, 32'h0, c + lat + 1 + k * (lat + 2));
      else            push(d, ARB_M1, 1'b1, WR_HALF, RD_LW, 32'h40, 32'hCAFE0001, c + lat + 1 + k * (lat + 2));
    wait_acks(d, 4);
    drive(d, ARB_M0, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    drive(d, ARB_M1, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
  endtask

  initial begin
    int c;
    rst_a = 1'b0; rst_b = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 2; w++) drive(d, w[0], 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b1; rst_b = 1'b1;

    // LATENCY=1
    fairness(0, 1);
    single(0, ARB_M0, 1'b0, WR_WORD, RD_LW, 32'h10, 32'h0, 1);

    // LATENCY=3
    fairness(1, 3);
    single(1, ARB_M1, 1'b1, WR_WORD, RD_LW, 32'h20, 32'h12345678, 3);

    // m0 moves its address mid-access; the port must keep the captured 0x10
    @(posedge clk); #1;
    c = cyc;
    drive(1, ARB_M0, 1'b1, 1'b0, WR_WORD, RD_LBU, 32'h10, 32'h0);
    push(1, ARB_M0, 1'b0, WR_WORD, RD_LBU, 32'h10, 32'h0, c + 4);
    repeat (2) @(posedge clk); #1;
    drive(1, ARB_M0, 1'b1, 1'b0, WR_WORD, RD_LBU, 32'h44, 32'h0);
    wait_acks(1, 1);
    drive(1, ARB_M0, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);

    // m0 pulses req while m1 is in its access phase and then withdraws
    @(posedge clk); #1;
    c = cyc;
    drive(1, ARB_M1, 1'b1, 1'b1, WR_BYTE, RD_LW, 32'h50, 32'hA5A50050);
    push(1, ARB_M1, 1'b1, WR_BYTE, RD_LW, 32'h50, 32'hA5A50050, c + 4);
    @(posedge clk); #1;
    drive(1, ARB_M0, 1'b1, 1'b0, WR_WORD, RD_LW, 32'h60, 32'h0);
    @(posedge clk); #1;
    drive(1, ARB_M0, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    wait_acks(1, 1);
    drive(1, ARB_M1, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    repeat (6) @(posedge clk);

    // reset in the second access cycle aborts the read with no ack
    #1;
    drive(1, ARB_M0, 1'b1, 1'b0, WR_WORD, RD_LW, 32'h70, 32'h0);
    push(1, ARB_M0, 1'b0, WR_WORD, RD_LW, 32'h70, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b0;
    drive(1, ARB_M0, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;

    // tie straight after reset: m0 first, then m1
    @(posedge clk); #1;
    c = cyc;
    drive(1, ARB_M0, 1'b1, 1'b0, WR_WORD, RD_LW, 32'h80, 32'h0);
    drive(1, ARB_M1, 1'b1, 1'b0, WR_WORD, RD_LB, 32'h90, 32'h0);
    push(1, ARB_M0, 1'b0, WR_WORD, RD_LW, 32'h80, 32'h0, c + 4);
    push(1, ARB_M1, 1'b0, WR_WORD, RD_LB, 32'h90, 32'h0, c + 9);
    wait_acks(1, 2);
    drive(1, ARB_M0, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    drive(1, ARB_M1, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);

    repeat (4) @(posedge clk);
    fin_req = 1;
    for (int i = 0; i < 10 && !fin_done; i++) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single data-memory port between two requesters.
- m0 is the multi-cycle CPU datapath (load/store access phase); m1 is the program loader / debug port.
- Round-robin arbitration, fixed-latency memory timing, and a req/ack handshake per requester.
- Placed between the requesters and the DM instance; DM port semantics (MemR, MemWr, MemWrBits, MemRBits) are passed through unchanged.

Parameters:
- LATENCY, 1, cycles the memory strobes are held per access; legal range 1..15, 0 is illegal.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- m0_req  input  1  m0 transaction request, held until m0_ack
- m0_we  input  1  1 = write, 0 = read
- m0_wrbits  input  2  write size code (DM MemWrBits encoding)
- m0_rbits  input  3  read size/sign code (DM MemRBits encoding)
- m0_addr  input  AW  byte address
- m0_wdata  input  DW  write data
- m0_ack  output  1  one-cycle completion pulse
- m0_rdata  output  DW  read data, valid while m0_ack=1
- m1_req, m1_we, m1_wrbits, m1_rbits, m1_addr, m1_wdata, m1_ack, m1_rdata: identical to the m0 ports, for m1
- mem_rd  output  1  DM MemR
- mem_wr  output  1  DM MemWr
- mem_wrbits  output  2  DM MemWrBits
- mem_rbits  output  3  DM MemRBits
- mem_addr  output  AW  DM addr
- mem_wdata  output  DW  DM data
- mem_rdata  input  DW  DM ReadData
- busy  output  1  1 whenever state is not IDLE
- owner  output  1  requester being served (0 = m0, 1 = m1); holds its last value while IDLE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, counter=0, last_grant=1, so m0 wins the first tie.
  - All outputs 0. Captured registers 0.
  - Reset asserted mid-ACCESS aborts the access: strobes drop immediately and no ack is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples m0_req/m1_req each cycle.
  - Only one request: that requester is granted.
  - Both requesting: grant goes to !last_grant (round-robin).
  - On grant: capture we/wrbits/rbits/addr/wdata of the winner into internal registers; set owner and last_grant; counter=LATENCY-1; next state ACCESS.
- ACCESS:
  - Drive mem_* from the captured registers only: mem_rd = !we, mem_wr = we.
  - Requester input changes during ACCESS have no effect.
  - counter decrements each cycle.
  - When counter==0: capture mem_rdata into rdata_q (reads only; writes leave rdata_q unchanged); next state RESP.
  - Strobes are high for exactly LATENCY consecutive cycles.
- RESP:
  - Strobes low.
  - owner's ack=1 for exactly one cycle; its rdata = rdata_q.
  - The non-owner's ack stays 0 and its rdata is 0.
  - Requests are ignored in RESP. Next state IDLE.
- Timing:
  - Request seen at edge t: strobes asserted in cycles t+1 .. t+LATENCY; ack in cycle t+LATENCY+1.
  - Minimum spacing between the starts of two transactions is LATENCY+2 cycles.
- Handshake:
  - A requester keeps req and its fields stable until its ack.
  - A req still high in the IDLE cycle after ack is a new transaction.
  - A requester that drops req before ack while waiting in IDLE (not yet granted) is withdrawn, with no side effects.
- Fairness: under continuous requests from both, grants alternate m0,m1,m0,…; neither requester waits more than one transaction.
- rdata outputs are 0 whenever the corresponding ack=0.

Decomposition:
- Shared package ctrl_encode_def: state encodings (ARB_IDLE=2'd0, ARB_ACCESS=2'd1, ARB_RESP=2'd2) and the requester IDs (ARB_M0=1'b0, ARB_M1=1'b1), alongside the existing MemWrBits/MemRBits codes.
- No sub-module. The round-robin pick is a few lines kept inline. The captured request reuses the existing Register module only if WriteSignal-gated capture fits, otherwise plain flops.

Test Plan:
- LATENCY=1, m0 read at addr 0x10 with mem_rdata=0xDEADBEEF → mem_rd high for 1 cycle at t+1; m0_ack=1 with m0_rdata=0xDEADBEEF at t+2; m1_ack=0.
- LATENCY=3, m1 write of 0x12345678 to 0x20 with wrbits=2'b00 → mem_wr high for cycles t+1..t+3 with addr/data stable; m1_ack at t+4; mem_rd never high.
- Both req held high for 4 transactions from reset → owner sequence 0,1,0,1; each ack pulses once per transaction.
- m0 changes m0_addr from 0x10 to 0x44 during ACCESS → mem_addr stays 0x10 for the whole access.
- rst driven low in the 2nd ACCESS cycle (LATENCY=3) → mem_rd/mem_wr/busy go 0 asynchronously; no ack; after release an m1 request is served first in the tie case only if m0 is absent, otherwise m0 wins.
- m0 req pulses high then low in IDLE while m1 is being served → m0 is never granted and m0_ack stays 0.
